// File: rtl/hdlc_tx_if.sv
// Producer-side byte stream, abort request and serial line/status of the HDLC transmit framer.
interface hdlc_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_abort_frame;
  logic       tx;
  logic       tx_done;
  logic       tx_aborted;
  logic       tx_underrun;

  modport master (
    output tx_data, tx_valid, tx_last, tx_abort_frame,
    input  tx_ready, tx, tx_done, tx_aborted, tx_underrun
  );

  modport slave (
    input  tx_data, tx_valid, tx_last, tx_abort_frame,
    output tx_ready, tx, tx_done, tx_aborted, tx_underrun
  );
endinterface

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, LSB-first data with zero insertion, optional CRC-16 FCS,
// abort sequence on request or underrun. One-byte holding register feeds an 8-bit shifter.
module hdlc_tx_framer #(
  parameter int unsigned FCS_EN = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  hdlc_tx_if.slave  bus
);

  localparam int unsigned CNT_W    = 5;
  localparam int unsigned ONES_W   = 3;
  localparam int unsigned CRC_W    = 16;
  localparam logic [7:0]  FLAG     = 8'h7E;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'hA001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN_FLAG,
    S_DATA,
    S_FCS,
    S_CLOSE_FLAG,
    S_ABORT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                last_q, last_d;
  logic                hold_full_q, hold_full_d;
  logic [7:0]          hold_data_q, hold_data_d;
  logic                hold_last_q, hold_last_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                underrun_q, underrun_d;
  logic                abort_prev_q, abort_prev_d;

  logic accept_c;
  logic abort_rise_c;

  // Reflected CRC-16 (0xA001) single-bit update
  function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] c, input logic b);
    logic [CRC_W-1:0] sh;
    sh = c >> 1;
    if (c[0] ^ b) begin
      sh = sh ^ CRC_POLY;
    end
    return sh;
  endfunction

  assign accept_c     = bus.tx_valid && ready_q;
  assign abort_rise_c = bus.tx_abort_frame && !abort_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      crc_q        <= '0;
      ones_q       <= '0;
      tx_q         <= 1'b1;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      underrun_q   <= 1'b0;
      abort_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      crc_q        <= crc_d;
      ones_q       <= ones_d;
      tx_q         <= tx_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      underrun_q   <= underrun_d;
      abort_prev_q <= abort_prev_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    last_d       = last_q;
    hold_full_d  = hold_full_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    crc_d        = crc_q;
    ones_d       = ones_q;
    tx_d         = 1'b1;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    underrun_d   = 1'b0;
    abort_prev_d = bus.tx_abort_frame;

    if (accept_c) begin
      hold_full_d = 1'b1;
      hold_data_d = bus.tx_data;
      hold_last_d = bus.tx_last;
    end

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          tx_d    = FLAG[0];
          cnt_d   = CNT_W'(1);
          crc_d   = '0;
          ones_d  = '0;
          state_d = S_OPEN_FLAG;
        end
      end

      S_OPEN_FLAG: begin
        tx_d   = FLAG[cnt_q[2:0]];
        crc_d  = '0;
        ones_d = '0;
        cnt_d  = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q == CNT_W'(7)) begin
          shift_d     = hold_data_q;
          last_d      = hold_last_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_DATA;
        end
      end

      S_DATA: begin
        if (ones_q == ONES_W'(5)) begin
          tx_d   = 1'b0;
          ones_d = '0;
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          crc_d   = crc_next(crc_q, shift_q[0]);
          ones_d  = shift_q[0] ? ONES_W'(ones_q + ONES_W'(1)) : '0;
          cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            if (last_q) begin
              state_d = (FCS_EN != 0) ? S_FCS : S_CLOSE_FLAG;
            end else if (hold_full_q) begin
              shift_d     = hold_data_q;
              last_d      = hold_last_q;
              hold_full_d = 1'b0;
            end else begin
              underrun_d = 1'b1;
              state_d    = S_ABORT;
            end
          end
        end
      end

      S_FCS: begin
        if (ones_q == ONES_W'(5)) begin
          tx_d   = 1'b0;
          ones_d = '0;
        end else begin
          tx_d   = crc_q[0];
          crc_d  = crc_q >> 1;
          ones_d = crc_q[0] ? ONES_W'(ones_q + ONES_W'(1)) : '0;
          cnt_d  = CNT_W'(cnt_q + CNT_W'(1));
          if (cnt_q == CNT_W'(15)) begin
            cnt_d   = '0;
            state_d = S_CLOSE_FLAG;
          end
        end
      end

      S_CLOSE_FLAG: begin
        // A run of five ones left by the last data/FCS bit still needs its stuffed zero
        if (ones_q == ONES_W'(5)) begin
          tx_d   = 1'b0;
          ones_d = '0;
        end else begin
          tx_d   = FLAG[cnt_q[2:0]];
          ones_d = '0;
          cnt_d  = CNT_W'(cnt_q + CNT_W'(1));
          if (cnt_q == CNT_W'(7)) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = hold_full_q ? S_OPEN_FLAG : S_IDLE;
          end
        end
      end

      S_ABORT: begin
        tx_d  = (cnt_q != '0);
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q == CNT_W'(7)) begin
          aborted_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort request wins over everything, including a running abort (restart)
    if (abort_rise_c) begin
      state_d    = S_ABORT;
      tx_d       = 1'b0;
      cnt_d      = CNT_W'(1);
      done_d     = 1'b0;
      aborted_d  = 1'b0;
      underrun_d = 1'b0;
    end

    if (state_d == S_ABORT) begin
      hold_full_d = 1'b0;
      shift_d     = '0;
      last_d      = 1'b0;
      crc_d       = '0;
      ones_d      = '0;
    end

    ready_d = !hold_full_d && (state_d != S_ABORT);
  end

  assign bus.tx          = tx_q;
  assign bus.tx_ready    = ready_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_aborted  = aborted_q;
  assign bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Bench for hdlc_tx_framer: expected line bits queued per scenario, compared bit by bit as
// the serial stream appears. Two instances cover FCS_EN=1 and FCS_EN=0.
module tb_hdlc_tx_framer;

  typedef struct packed {
    logic       tx;
    logic       done;
    logic       ab;
    logic       ur;
    logic [1:0] act;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d_r;
  logic       v_r, l_r, ab_r;
  logic       sel0;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int m_ones    = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hdlc_tx_if ifc1 ();
  hdlc_tx_if ifc0 ();

  assign ifc1.tx_data        = d_r;
  assign ifc1.tx_valid       = v_r;
  assign ifc1.tx_last        = l_r;
  assign ifc1.tx_abort_frame = ab_r;
  assign ifc0.tx_data        = d_r;
  assign ifc0.tx_valid       = v_r;
  assign ifc0.tx_last        = l_r;
  assign ifc0.tx_abort_frame = ab_r;

  hdlc_tx_framer #(.FCS_EN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));
  hdlc_tx_framer #(.FCS_EN(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));

  logic m_tx, m_done, m_ab, m_ur, m_ready;
  assign m_tx    = sel0 ? ifc0.tx          : ifc1.tx;
  assign m_done  = sel0 ? ifc0.tx_done     : ifc1.tx_done;
  assign m_ab    = sel0 ? ifc0.tx_aborted  : ifc1.tx_aborted;
  assign m_ur    = sel0 ? ifc0.tx_underrun : ifc1.tx_underrun;
  assign m_ready = sel0 ? ifc0.tx_ready    : ifc1.tx_ready;

  // ---------------- expected-stream builders ----------------
  task automatic push_bit(input logic tx, input logic dn, input logic ab, input logic ur,
                          input logic [1:0] act);
    exp_t e;
    e.tx = tx; e.done = dn; e.ab = ab; e.ur = ur; e.act = act;
    exp_q.push_back(e);
  endtask

  task automatic push_flag(input logic closing);
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) push_bit(f[i], closing && (i == 7), 1'b0, 1'b0, 2'd0);
    m_ones = 0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int nbits, input logic ur_last);
    for (int i = 0; i < nbits; i++) begin
      if (m_ones == 5) begin
        push_bit(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        m_ones = 0;
      end
      push_bit(b[i], 1'b0, 1'b0, ur_last && (i == 7), 2'd0);
      m_ones = b[i] ? m_ones + 1 : 0;
    end
  endtask

  task automatic push_close();
    if (m_ones == 5) push_bit(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    push_flag(1'b1);
  endtask

  task automatic push_abort_tail();
    push_bit(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 1; i <= 7; i++) push_bit(1'b1, 1'b0, i == 7, 1'b0, 2'd0);
  endtask

  task automatic set_last_act(input logic [1:0] act);
    exp_t e;
    e = exp_q.pop_back();
    e.act = act;
    exp_q.push_back(e);
  endtask

  // ---------------- stimulus / monitor helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; v_r = 1'b0; ab_r = 1'b0; l_r = 1'b0; d_r = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    d_r = b; l_r = last; v_r = 1'b1;
    while (m_ready !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      total_cnt++;
      $display("FAIL send_byte: tx_ready=%b, required 1 within 300 cycles", m_ready);
    end
    @(posedge clk);
    #1 v_r = 1'b0;
  endtask

  task automatic check_stream(input string name);
    int   guard;
    int   idx;
    exp_t e;
    guard = 0;
    idx   = 0;
    @(negedge clk);
    while (m_tx !== 1'b0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    total_cnt++;
    if (guard >= 400) begin
      $display("FAIL %s start: tx=%b, required first 0 within 400 cycles", name, m_tx);
      exp_q.delete();
    end else begin
      pass_cnt++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if ({m_tx, m_done, m_ab, m_ur} !== {e.tx, e.done, e.ab, e.ur})
        $display("FAIL %s bit %0d: tx/done/aborted/underrun=%b, required %b",
                 name, idx, {m_tx, m_done, m_ab, m_ur}, {e.tx, e.done, e.ab, e.ur});
      else pass_cnt++;
      if (e.act == 2'd1) ab_r = 1'b1;
      else if (e.act == 2'd2) ab_r = 1'b0;
      idx++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    repeat (3) begin
      @(negedge clk);
      total_cnt++;
      if ({m_tx, m_done, m_ab, m_ur} !== 4'b1000)
        $display("FAIL %s idle: tx/done/aborted/underrun=%b, required 1000",
                 name, {m_tx, m_done, m_ab, m_ur});
      else pass_cnt++;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total_cnt++;
    if ({m_tx, m_ready, m_done, m_ab, m_ur} !== 5'b11000)
      $display("FAIL %s: tx/ready/done/aborted/underrun=%b, required 11000",
               name, {m_tx, m_ready, m_done, m_ab, m_ur});
    else pass_cnt++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; v_r = 1'b0; l_r = 1'b0; ab_r = 1'b0; d_r = 8'h00;
    repeat (3) @(negedge clk);
    sel0 = 1'b0;
    check_idle_outputs("reset fcs1");
    sel0 = 1'b1;
    check_idle_outputs("reset fcs0");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    do_reset();
    sel0 = 1'b0;
    push_flag(1'b0);
    push_byte(8'h01, 8, 1'b0);
    push_byte(8'hC1, 8, 1'b0);
    push_byte(8'hC0, 8, 1'b0);
    push_close();
    fork
      send_byte(8'h01, 1'b1);
      check_stream("single_0x01");
    join
  endtask

  task automatic test_check_string();
    logic [7:0] s [9];
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    do_reset();
    sel0 = 1'b0;
    push_flag(1'b0);
    for (int i = 0; i < 9; i++) push_byte(s[i], 8, 1'b0);
    push_byte(8'h3D, 8, 1'b0);
    push_byte(8'hBB, 8, 1'b0);
    push_close();
    fork
      for (int i = 0; i < 9; i++) send_byte(s[i], i == 8);
      check_stream("crc_123456789");
    join
  endtask

  task automatic test_stuffing_nofcs();
    logic [7:0] pat [2];
    pat = '{8'hFF, 8'hF8};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      sel0 = 1'b1;
      push_flag(1'b0);
      push_byte(pat[k], 8, 1'b0);
      push_close();
      fork
        send_byte(pat[k], 1'b1);
        check_stream(k == 0 ? "stuff_0xFF" : "stuff_0xF8");
      join
    end
  endtask

  task automatic test_abort_midframe();
    do_reset();
    sel0 = 1'b0;
    push_flag(1'b0);
    push_byte(8'h11, 8, 1'b0);
    push_byte(8'h22, 8, 1'b0);
    push_byte(8'h33, 4, 1'b0);
    set_last_act(2'd1);
    push_abort_tail();
    fork
      begin
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
      end
      check_stream("abort_byte3");
    join
    ab_r = 1'b0;
  endtask

  task automatic test_abort_restart();
    do_reset();
    sel0 = 1'b0;
    push_bit(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    push_bit(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    push_abort_tail();
    fork
      begin
        @(negedge clk);
        ab_r = 1'b1;
      end
      check_stream("abort_restart");
    join
    ab_r = 1'b0;
  endtask

  task automatic test_underrun();
    do_reset();
    sel0 = 1'b0;
    push_flag(1'b0);
    push_byte(8'hAA, 8, 1'b1);
    push_abort_tail();
    fork
      send_byte(8'hAA, 1'b0);
      check_stream("underrun");
      begin
        int guard;
        guard = 0;
        @(negedge clk);
        while (m_ur !== 1'b1 && guard < 300) begin
          @(negedge clk);
          guard++;
        end
        @(negedge clk);
        total_cnt++;
        if (m_ready !== 1'b0)
          $display("FAIL underrun ready_in_abort: tx_ready=%b, required 0", m_ready);
        else pass_cnt++;
      end
    join
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [9];
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    do_reset();
    sel0 = 1'b0;
    push_flag(1'b0);
    push_byte(8'h01, 8, 1'b0);
    push_byte(8'hC1, 8, 1'b0);
    push_byte(8'hC0, 8, 1'b0);
    push_close();
    push_flag(1'b0);
    for (int i = 0; i < 9; i++) push_byte(s[i], 8, 1'b0);
    push_byte(8'h3D, 8, 1'b0);
    push_byte(8'hBB, 8, 1'b0);
    push_close();
    fork
      begin
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 9; i++) send_byte(s[i], i == 8);
      end
      check_stream("back_to_back");
    join
  endtask

  task automatic test_reset_mid_fcs();
    do_reset();
    sel0 = 1'b0;
    fork
      send_byte(8'h01, 1'b1);
      begin
        int guard;
        guard = 0;
        @(negedge clk);
        while (m_tx !== 1'b0 && guard < 300) begin
          @(negedge clk);
          guard++;
        end
        repeat (18) @(negedge clk);
        total_cnt++;
        if (m_tx !== 1'b0)
          $display("FAIL mid_fcs bit: tx=%b, required 0 (third FCS bit)", m_tx);
        else pass_cnt++;
        rst_n = 1'b0;
        #1 check_idle_outputs("reset_during_fcs");
      end
    join
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    push_flag(1'b0);
    push_byte(8'h01, 8, 1'b0);
    push_byte(8'hC1, 8, 1'b0);
    push_byte(8'hC0, 8, 1'b0);
    push_close();
    fork
      send_byte(8'h01, 1'b1);
      check_stream("after_reset_frame");
    join
  endtask

  initial begin
    sel0 = 1'b0;
    test_reset();
    test_single_byte();
    test_check_string();
    test_stuffing_nofcs();
    test_abort_midframe();
    test_abort_restart();
    test_underrun();
    test_back_to_back();
    test_reset_mid_fcs();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
